sid_write_sequencer: RTL

Programmable SID register-write sequencer that replaces ad-hoc hardcoded programming logic at the top level. Plays a loadable table of (register, data, wait) entries onto the `mos6581` bus interface (`addr`, `data`, `n_cs`), paced by the 1 MHz `clk_en` tick from `clk_div`. Supports one-shot and loop modes and start/stop/busy/done handshakes. Sits between a host source (UART decoder or boot ROM loader) and `sid1`.

---
 rtl/sid_pkg.sv | 29 ++
 rtl/sid_write_sequencer_if.sv | 47 ++++
 rtl/sid_seq_ram.sv | 26 ++
 rtl/sid_write_sequencer.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/sid_pkg.sv
// Shared SID definitions.
//   SID_ADDR_W / SID_DATA_W : mos6581 register bus widths
//   sid_reg_e               : named voice-1 / global SID registers
//   seq_state_e             : states of the register-write sequencer
package sid_pkg;

  localparam int SID_ADDR_W = 5;
  localparam int SID_DATA_W = 8;

  typedef enum logic [SID_ADDR_W-1:0] {
    FREQ_LO  = 5'h00,
    FREQ_HI  = 5'h01,
    PW_LO    = 5'h02,
    PW_HI    = 5'h03,
    CTRL     = 5'h04,
    AD       = 5'h05,
    SR       = 5'h06,
    MODE_VOL = 5'h18
  } sid_reg_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_HOLD,
    S_WAIT,
    S_ADV
  } seq_state_e;

endpackage

// File: rtl/sid_write_sequencer_if.sv
// Host-side and SID-side signal bundle of the write sequencer.
//   master : host (UART decoder / boot loader) plus whatever observes the SID bus
//   slave  : the sequencer itself
// Table programming: prog_we/prog_idx/prog_addr/prog_data/prog_wait
// Control:           length, loop_en, start, stop
// Status:            busy, done, prog_err, cur_idx
// SID bus:           sid_addr, sid_data, sid_n_cs (active low)
interface sid_write_sequencer_if #(
  parameter int DEPTH  = 16,
  parameter int WAIT_W = 16
);
  import sid_pkg::*;

  localparam int IDX_W = $clog2(DEPTH);

  logic                  prog_we;
  logic [IDX_W-1:0]      prog_idx;
  logic [SID_ADDR_W-1:0] prog_addr;
  logic [SID_DATA_W-1:0] prog_data;
  logic [WAIT_W-1:0]     prog_wait;
  logic [IDX_W:0]        length;
  logic                  loop_en;
  logic                  start;
  logic                  stop;
  logic                  busy;
  logic                  done;
  logic                  prog_err;
  logic [IDX_W-1:0]      cur_idx;
  logic [SID_ADDR_W-1:0] sid_addr;
  logic [SID_DATA_W-1:0] sid_data;
  logic                  sid_n_cs;

  modport master (
    output prog_we, prog_idx, prog_addr, prog_data, prog_wait,
    output length, loop_en, start, stop,
    input  busy, done, prog_err, cur_idx,
    input  sid_addr, sid_data, sid_n_cs
  );

  modport slave (
    input  prog_we, prog_idx, prog_addr, prog_data, prog_wait,
    input  length, loop_en, start, stop,
    output busy, done, prog_err, cur_idx,
    output sid_addr, sid_data, sid_n_cs
  );

endinterface

// File: rtl/sid_seq_ram.sv
// Sequence table storage: DEPTH entries of ENTRY_W bits.
//   clk     : write clock
//   we      : write strobe, wr_idx/wr_data captured on the rising edge
//   rd_idx  : read index, rd_data follows combinationally
// Contents are intentionally not reset.
module sid_seq_ram #(
  parameter int DEPTH   = 16,
  parameter int ENTRY_W = 29
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] wr_idx,
  input  logic [ENTRY_W-1:0]       wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_idx,
  output logic [ENTRY_W-1:0]       rd_data
);

  logic [ENTRY_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_idx] <= wr_data;
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/sid_write_sequencer.sv
// Plays a table of (register, data, wait) entries onto the mos6581 bus,
// paced by the 1 MHz SID clock enable.
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   tick : single-cycle pacing enable (SID clk_en)
//   bus  : table programming, start/stop control, status and SID bus
// Each entry costs ISSUE tick (n_cs falls) + HOLD tick (n_cs rises) + wait
// ticks + one ADV clock, so the SID sees n_cs low on exactly one clk_en.
module sid_write_sequencer
  import sid_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int WAIT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  sid_write_sequencer_if.slave bus
);

  localparam int IDX_W   = $clog2(DEPTH);
  localparam int ENTRY_W = SID_ADDR_W + SID_DATA_W + WAIT_W;
  localparam logic [IDX_W:0] DEPTH_L = (IDX_W+1)'(DEPTH);

  seq_state_e            state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [IDX_W:0]        len_q, len_d;
  logic                  loop_q, loop_d;
  logic [WAIT_W-1:0]     cnt_q, cnt_d;
  logic                  stop_pend_q, stop_pend_d;
  logic                  n_cs_q, n_cs_d;
  logic [SID_ADDR_W-1:0] addr_q, addr_d;
  logic [SID_DATA_W-1:0] data_q, data_d;
  logic                  done_q, done_d;
  logic                  prog_err_q;

  logic                  busy;
  logic                  len_ok;
  logic                  is_last;
  logic [ENTRY_W-1:0]    rd_entry;
  logic [SID_ADDR_W-1:0] rd_addr;
  logic [SID_DATA_W-1:0] rd_data;
  logic [WAIT_W-1:0]     rd_wait;

  assign busy = (state_q != S_IDLE);

  sid_seq_ram #(
    .DEPTH   (DEPTH),
    .ENTRY_W (ENTRY_W)
  ) u_ram (
    .clk     (clk),
    .we      (bus.prog_we && !busy),
    .wr_idx  (bus.prog_idx),
    .wr_data ({bus.prog_addr, bus.prog_data, bus.prog_wait}),
    .rd_idx  (idx_q),
    .rd_data (rd_entry)
  );

  assign {rd_addr, rd_data, rd_wait} = rd_entry;

  assign len_ok  = (bus.length != '0) && (bus.length <= DEPTH_L);
  assign is_last = ({1'b0, idx_q} == (len_q - 1'b1));

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    len_d       = len_q;
    loop_d      = loop_q;
    cnt_d       = cnt_q;
    stop_pend_d = stop_pend_q;
    n_cs_d      = n_cs_q;
    addr_d      = addr_q;
    data_d      = data_q;
    done_d      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        stop_pend_d = 1'b0;
        // stop wins over a simultaneous start
        if (bus.start && !bus.stop && len_ok) begin
          len_d   = bus.length;
          loop_d  = bus.loop_en;
          idx_d   = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (bus.stop) begin
          state_d = S_IDLE;
        end else if (tick) begin
          addr_d  = rd_addr;
          data_d  = rd_data;
          n_cs_d  = 1'b0;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        // a stop here must not truncate the write: remember it until the
        // tick that releases n_cs
        if (bus.stop) stop_pend_d = 1'b1;
        if (tick) begin
          n_cs_d = 1'b1;
          cnt_d  = rd_wait;
          if (bus.stop || stop_pend_q) state_d = S_IDLE;
          else if (rd_wait == '0)      state_d = S_ADV;
          else                         state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.stop) begin
          state_d = S_IDLE;
        end else if (tick) begin
          cnt_d = cnt_q - WAIT_W'(1);
          if (cnt_q == WAIT_W'(1)) state_d = S_ADV;
        end
      end
      S_ADV: begin
        if (bus.stop) begin
          state_d = S_IDLE;
        end else if (!is_last) begin
          idx_d   = idx_q + 1'b1;
          state_d = S_ISSUE;
        end else if (loop_q) begin
          idx_d   = '0;
          state_d = S_ISSUE;
        end else begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      len_q       <= '0;
      loop_q      <= 1'b0;
      cnt_q       <= '0;
      stop_pend_q <= 1'b0;
      n_cs_q      <= 1'b1;
      addr_q      <= '0;
      data_q      <= '0;
      done_q      <= 1'b0;
      prog_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      loop_q      <= loop_d;
      cnt_q       <= cnt_d;
      stop_pend_q <= stop_pend_d;
      n_cs_q      <= n_cs_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      done_q      <= done_d;
      prog_err_q  <= bus.prog_we && busy;
    end
  end

  assign bus.busy     = busy;
  assign bus.done     = done_q;
  assign bus.prog_err = prog_err_q;
  assign bus.cur_idx  = idx_q;
  assign bus.sid_addr = addr_q;
  assign bus.sid_data = data_q;
  assign bus.sid_n_cs = n_cs_q;

endmodule
